// File: rtl/program_loader_if.sv
// Stream input and RAM write port of the program loader.
// LOADER_READBACK_EN adds the RAM read-data return path rb_data.
interface program_loader_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rw;
    logic [DATA_W-1:0] mem_data;
`ifdef LOADER_READBACK_EN
    logic [DATA_W-1:0] rb_data;
`endif

    // master: the loader itself; slave: stream source plus RAM
    modport master (
        input  in_valid, in_data,
`ifdef LOADER_READBACK_EN
        input  rb_data,
`endif
        output in_ready, mem_addr, mem_rw, mem_data
    );
    modport slave (
        output in_valid, in_data,
`ifdef LOADER_READBACK_EN
        output rb_data,
`endif
        input  in_ready, mem_addr, mem_rw, mem_data
    );
endinterface

// File: rtl/program_loader.sv
// Loads a framed byte stream (length, words, checksum) into the instruction RAM.
// Optional LOADER_READBACK_EN re-reads the RAM and checks its sum before DONE.
module program_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    program_loader_if.master  bus,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR, S_VERIFY
    } state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] ptr, ptr_d;
    logic [ADDR_W:0]   count, count_d;
    logic [DATA_W-1:0] sum, sum_d;
    logic [DATA_W-1:0] wbyte, wbyte_d;
    logic              rdy_q, rdy_d;
    logic              xfer;
`ifdef LOADER_READBACK_EN
    logic [ADDR_W:0]   n_len, n_len_d;
    logic [ADDR_W:0]   vcnt, vcnt_d;
    logic [DATA_W-1:0] rb_sum, rb_sum_d, rb_acc;
    logic              rb_pend, rb_pend_d;
`endif

    assign xfer = bus.in_valid && rdy_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= S_IDLE;
            ptr     <= '0;
            count   <= '0;
            sum     <= '0;
            wbyte   <= '0;
            rdy_q   <= 1'b0;
`ifdef LOADER_READBACK_EN
            n_len   <= '0;
            vcnt    <= '0;
            rb_sum  <= '0;
            rb_pend <= 1'b0;
`endif
        end else begin
            state   <= state_d;
            ptr     <= ptr_d;
            count   <= count_d;
            sum     <= sum_d;
            wbyte   <= wbyte_d;
            rdy_q   <= rdy_d;
`ifdef LOADER_READBACK_EN
            n_len   <= n_len_d;
            vcnt    <= vcnt_d;
            rb_sum  <= rb_sum_d;
            rb_pend <= rb_pend_d;
`endif
        end
    end

    always_comb begin
        state_d   = state;
        ptr_d     = ptr;
        count_d   = count;
        sum_d     = sum;
        wbyte_d   = wbyte;
`ifdef LOADER_READBACK_EN
        n_len_d   = n_len;
        vcnt_d    = vcnt;
        rb_sum_d  = rb_sum;
        rb_pend_d = rb_pend;
        rb_acc    = rb_pend ? rb_sum + bus.rb_data : rb_sum;
`endif
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN;
                    ptr_d   = '0;
                    sum_d   = '0;
                end
            end
            S_LEN: begin
                if (xfer) begin
                    if (bus.in_data == '0 || int'(bus.in_data) > DEPTH) begin
                        state_d = S_ERR;
                    end else begin
                        count_d = (ADDR_W+1)'(bus.in_data);
`ifdef LOADER_READBACK_EN
                        n_len_d = (ADDR_W+1)'(bus.in_data);
`endif
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    wbyte_d = bus.in_data;
                    sum_d   = sum + bus.in_data;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // ptr wraps naturally, so a full-depth frame leaves it at 0
                ptr_d   = ptr + 1'b1;
                count_d = count - 1'b1;
                state_d = (count == 1) ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                if (xfer) begin
                    if (bus.in_data == sum) begin
`ifdef LOADER_READBACK_EN
                        state_d   = S_VERIFY;
                        vcnt_d    = '0;
                        rb_sum_d  = '0;
                        rb_pend_d = 1'b0;
`else
                        state_d   = S_DONE;
`endif
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
`ifdef LOADER_READBACK_EN
            S_VERIFY: begin
                // read data lags the address by one cycle; the last word lands on cycle N
                rb_sum_d = rb_acc;
                if (vcnt < n_len) begin
                    vcnt_d    = vcnt + 1'b1;
                    rb_pend_d = 1'b1;
                end else begin
                    rb_pend_d = 1'b0;
                    state_d   = (rb_acc == sum) ? S_DONE : S_ERR;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
        rdy_d = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
    end

    assign bus.in_ready = rdy_q;
    assign bus.mem_rw   = (state != S_WRITE);
    assign bus.mem_data = wbyte;
`ifdef LOADER_READBACK_EN
    assign bus.mem_addr = (state == S_VERIFY) ? vcnt[ADDR_W-1:0] : ptr;
`else
    assign bus.mem_addr = ptr;
`endif
    assign cpu_hold = !((state == S_IDLE) || (state == S_DONE));
    assign done     = (state == S_DONE);
    assign err      = (state == S_ERR);

endmodule
